// File: rtl/shift_pack_pkg.sv
// Shared helpers for the serial-to-parallel packer: keep-mask thermometer,
// lane offset helper and the default word width.
package shift_pack_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned MAX_LANES  = 64;

  // Low `cnt` bits set, never beyond `lanes`.
  function automatic logic [MAX_LANES-1:0] therm_mask(int unsigned cnt, int unsigned lanes);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (i < cnt && i < lanes) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic int unsigned lane_lsb(int unsigned lane, int unsigned data_w);
    return lane * data_w;
  endfunction

endpackage

// File: rtl/shift_pack_out_reg.sv
// One-entry valid/ready output register holding a packed beat and its keep mask.
module shift_pack_out_reg #(
  parameter int unsigned BEAT_W = 256,
  parameter int unsigned LANES  = 8
) (
  input  logic              clk_data,
  input  logic              rst_n,
  input  logic              emit,
  input  logic [BEAT_W-1:0] emit_data,
  input  logic [LANES-1:0]  emit_keep,
  input  logic              ready,
  output logic              emit_ok,
  output logic [BEAT_W-1:0] data,
  output logic [LANES-1:0]  keep,
  output logic              valid
);

  assign emit_ok = !valid || ready;

  // A new beat may replace one being consumed in the same cycle, so no bubble.
  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      keep  <= '0;
      valid <= 1'b0;
    end else if (emit) begin
      data  <= emit_data;
      keep  <= emit_keep;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_pack_buffer.sv
// Packs LANES words of DATA_W bits into one wide beat, with partial-beat flush
// and a valid/ready output stage that backpressures the serial source.
module shift_pack_buffer
  import shift_pack_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LANES  = 8
) (
  input  logic                    clk_data,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       data_i,
  input  logic                    wr_en_i,
  input  logic                    flush_i,
  output logic                    wr_ready_o,
  output logic [DATA_W*LANES-1:0] data_o,
  output logic [LANES-1:0]        keep_o,
  output logic                    data_valid_o,
  input  logic                    data_ready_i,
  output logic                    overflow_o
);

  localparam int unsigned CNT_W = $clog2(LANES + 1);

  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        filled;
  logic [DATA_W*LANES-1:0] acc;
  logic [DATA_W*LANES-1:0] acc_next;
  logic [LANES-1:0]        emit_keep;
  logic                    emit_ok;
  logic                    full_pos;
  logic                    wr_acc;
  logic                    fl_acc;
  logic                    emit;

  // Only requests that would produce a beat need the output stage free.
  always_comb begin
    full_pos   = (cnt == CNT_W'(LANES - 1));
    wr_ready_o = (flush_i || full_pos) ? emit_ok : 1'b1;
    wr_acc     = wr_en_i && wr_ready_o;
    fl_acc     = flush_i && wr_ready_o;
    filled     = cnt + CNT_W'(wr_acc);
    acc_next   = acc;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (wr_acc && cnt == CNT_W'(k)) acc_next[lane_lsb(k, DATA_W) +: DATA_W] = data_i;
    end
    emit      = (wr_acc && full_pos) || (fl_acc && filled != '0);
    emit_keep = LANES'(therm_mask(32'(filled), LANES));
  end

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      acc        <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (emit) begin
        cnt <= '0;
        acc <= '0;
      end else if (wr_acc) begin
        cnt <= filled;
        acc <= acc_next;
      end
      if ((wr_en_i || flush_i) && !wr_ready_o) overflow_o <= 1'b1;
    end
  end

  shift_pack_out_reg #(
    .BEAT_W(DATA_W * LANES),
    .LANES (LANES)
  ) u_out_reg (
    .clk_data (clk_data),
    .rst_n    (rst_n),
    .emit     (emit),
    .emit_data(acc_next),
    .emit_keep(emit_keep),
    .ready    (data_ready_i),
    .emit_ok  (emit_ok),
    .data     (data_o),
    .keep     (keep_o),
    .valid    (data_valid_o)
  );

endmodule

// File: tb/tb_shift_pack_buffer.sv
// Scoreboard bench for shift_pack_buffer: instance a (32x8) and instance b (8x3).
module tb_shift_pack_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din[2];
  logic        wr[2], fl[2], rdy[2];
  int          mode[2];

  logic         a_wrr, a_valid, a_ovf, b_wrr, b_valid, b_ovf;
  logic [255:0] a_data;
  logic [7:0]   a_keep;
  logic [23:0]  b_data;
  logic [2:0]   b_keep;

  typedef struct { logic [255:0] d; logic [7:0] k; } beat_t;
  beat_t q0[$], q1[$];

  logic [31:0] pw[2][8];
  int unsigned pn[2];
  bit          busy[2], movf[2];
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  shift_pack_buffer #(.DATA_W(32), .LANES(8)) u_a (
    .clk_data(clk), .rst_n(rst_n), .data_i(din[0]), .wr_en_i(wr[0]), .flush_i(fl[0]),
    .wr_ready_o(a_wrr), .data_o(a_data), .keep_o(a_keep), .data_valid_o(a_valid),
    .data_ready_i(rdy[0]), .overflow_o(a_ovf));

  shift_pack_buffer #(.DATA_W(8), .LANES(3)) u_b (
    .clk_data(clk), .rst_n(rst_n), .data_i(din[1][7:0]), .wr_en_i(wr[1]), .flush_i(fl[1]),
    .wr_ready_o(b_wrr), .data_o(b_data), .keep_o(b_keep), .data_valid_o(b_valid),
    .data_ready_i(rdy[1]), .overflow_o(b_ovf));

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of pending words per instance; a beat is the
  // concatenation of the list once it holds LANES words or a flush arrives.
  task automatic model_step(int id);
    int unsigned lanes, w;
    logic [31:0]  d;
    logic         dut_wrr, dut_vld, dut_ovf;
    bit           er, wa, fa, emit;
    logic [255:0] bd;
    beat_t        b;
    string        pre;
    lanes   = (id == 0) ? 8 : 3;
    w       = (id == 0) ? 32 : 8;
    d       = (id == 0) ? din[0] : {24'b0, din[1][7:0]};
    dut_wrr = (id == 0) ? a_wrr : b_wrr;
    dut_vld = (id == 0) ? a_valid : b_valid;
    dut_ovf = (id == 0) ? a_ovf : b_ovf;
    pre     = (id == 0) ? "a_" : "b_";
    er = (fl[id] || pn[id] == lanes - 1) ? (!busy[id] || rdy[id]) : 1'b1;
    chk({pre, "wr_ready"}, 256'(dut_wrr), 256'(er));
    chk({pre, "data_valid"}, 256'(dut_vld), 256'(busy[id]));
    chk({pre, "overflow"}, 256'(dut_ovf), 256'(movf[id]));
    if ((wr[id] || fl[id]) && !er) movf[id] = 1'b1;
    wa = wr[id] && er;
    fa = fl[id] && er;
    if (wa) begin
      pw[id][pn[id]] = d;
      pn[id]++;
    end
    emit = (wa && pn[id] == lanes) || (fa && pn[id] > 0);
    if (emit) begin
      bd = '0;
      for (int unsigned k = 0; k < pn[id]; k++) bd = bd | (256'(pw[id][k]) << (k * w));
      b.d = bd;
      b.k = 8'((1 << pn[id]) - 1);
      if (id == 0) q0.push_back(b); else q1.push_back(b);
      pn[id]   = 0;
      busy[id] = 1'b1;
    end else if (busy[id] && rdy[id]) begin
      busy[id] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        pn[i] = 0; busy[i] = 1'b0; movf[i] = 1'b0;
      end
      q0.delete();
      q1.delete();
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic mon(int id);
    beat_t        e;
    logic         v;
    logic [255:0] d;
    logic [7:0]   k;
    v = (id == 0) ? a_valid : b_valid;
    d = (id == 0) ? a_data : {232'b0, b_data};
    k = (id == 0) ? a_keep : {5'b0, b_keep};
    if (v === 1'b1 && rdy[id]) begin
      if ((id == 0 ? q0.size() : q1.size()) == 0) begin
        chk(id == 0 ? "a_unexpected_beat" : "b_unexpected_beat", 256'(1), 256'(0));
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk(id == 0 ? "a_beat_data" : "b_beat_data", d, e.d);
        chk(id == 0 ? "a_beat_keep" : "b_beat_keep", 256'(k), 256'(e.k));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) rdy[i] = (mode[i] == 2) ? 1'($urandom_range(0, 1)) : (mode[i] != 0);
    end
  end

  // Holds the request until the handshake completes; called at posedge+1.
  task automatic put(int id, logic [31:0] d, bit w, bit f);
    logic acc;
    acc = 1'b0;
    din[id] = d; wr[id] = w; fl[id] = f;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = (id == 0) ? a_wrr : b_wrr;
      @(posedge clk);
      #1;
    end
    if (acc !== 1'b1) chk("put_timeout", 256'(acc), 256'(1));
    wr[id] = 1'b0; fl[id] = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_phase(int id, int n);
    bit w, f;
    mode[id] = 2;
    repeat (n) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
      w = $urandom_range(0, 5) != 0;
      f = $urandom_range(0, 5) == 0;
      if (!w && !f) w = 1'b1;
      put(id, $urandom, w, f);
    end
    mode[id] = 1;
    idle(10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din[i] = '0; wr[i] = 1'b0; fl[i] = 1'b0; rdy[i] = 1'b1; mode[i] = 1;
    end
    #2;
    chk("rst_a_valid", 256'(a_valid), 256'(0));
    chk("rst_a_data", a_data, 256'(0));
    chk("rst_a_keep", 256'(a_keep), 256'(0));
    chk("rst_a_wr_ready", 256'(a_wrr), 256'(1));
    chk("rst_b_valid", 256'(b_valid), 256'(0));
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // instance a: full beat, back-to-back beats, flush cases
    for (int i = 1; i <= 8; i++) put(0, 32'(i), 1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 16; i++) put(0, $urandom, 1'b1, 1'b0);
    idle(2);
    put(0, 32'hA, 1'b1, 1'b0);
    put(0, 32'hB, 1'b1, 1'b0);
    put(0, 32'hC, 1'b1, 1'b0);
    put(0, 32'h0, 1'b0, 1'b1);
    put(0, 32'h55, 1'b1, 1'b0);
    put(0, 32'h0, 1'b0, 1'b1);
    idle(2);
    put(0, 32'h0, 1'b0, 1'b1);
    put(0, 32'hD, 1'b1, 1'b1);
    idle(2);

    // backpressure: 16th write stalls with wr_en held
    mode[0] = 0;
    idle(1);
    fork
      for (int i = 0; i < 16; i++) put(0, $urandom, 1'b1, 1'b0);
      begin
        repeat (40) @(posedge clk);
        #1 mode[0] = 1;
      end
    join
    idle(3);
    @(negedge clk);
    chk("a_overflow_sticky", 256'(a_ovf), 256'(1));
    @(posedge clk);
    #1;

    // reset with a held beat and a partial accumulator
    mode[0] = 0;
    idle(1);
    for (int i = 0; i < 8; i++) put(0, $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) put(0, $urandom, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_a_valid", 256'(a_valid), 256'(0));
    chk("midrst_a_data", a_data, 256'(0));
    chk("midrst_a_keep", 256'(a_keep), 256'(0));
    chk("midrst_a_overflow", 256'(a_ovf), 256'(0));
    chk("midrst_a_wr_ready", 256'(a_wrr), 256'(1));
    mode[0] = 1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) put(0, 32'h100 + 32'(i), 1'b1, 1'b0);
    idle(3);
    rand_phase(0, 300);

    // instance b: 3 lanes of 8 bits
    for (int i = 1; i <= 3; i++) put(1, 32'(i), 1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 6; i++) put(1, $urandom, 1'b1, 1'b0);
    idle(2);
    put(1, 32'hA1, 1'b1, 1'b0);
    put(1, 32'hB2, 1'b1, 1'b0);
    put(1, 32'h0, 1'b0, 1'b1);
    put(1, 32'hC3, 1'b1, 1'b1);
    idle(2);
    rand_phase(1, 200);

    chk("a_queue_drained", 256'(q0.size()), 256'(0));
    chk("b_queue_drained", 256'(q1.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
